data_memory_bus: RTL and testbench
==================================

DATA_MEMORY_BUS -- requirements
Module: data_memory_bus

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL be the byte-address width; depth is 2**(ADDR_W-2) 32-bit words (8192 at default).
REQ-002 Parameter WAIT_CYCLES, default 0, range 0..15, SHALL be the number of extra wait cycles per access.
REQ-003 Parameter DATA_W SHALL be fixed at 32; other values are not supported.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  1  request valid.
REQ-007 we  in  1  1 = store, 0 = load; sampled with req.
REQ-008 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 uns  in  1  load zero-extend (lbu/lhu) when 1, sign-extend when 0.
REQ-010 addr  in  ADDR_W  byte address.
REQ-011 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 ready  out  1  request accepted on an edge where req && ready.
REQ-013 done  out  1  one-cycle pulse ending every accepted transaction.
REQ-014 err  out  1  valid with done; 1 = misaligned or reserved size.
REQ-015 rdata  out  32  load result, valid with done for loads; holds otherwise.

Function
REQ-016 FSM states IDLE, WAIT, DONE; ready SHALL be 1 only in IDLE.
REQ-017 Accept in IDLE -> WAIT with counter loaded WAIT_CYCLES-1 (WAIT_CYCLES>0), or -> DONE directly (WAIT_CYCLES=0).
REQ-018 WAIT decrements each cycle; at counter 0 -> DONE; DONE -> IDLE after exactly one cycle.
REQ-019 Latency: done SHALL be high in the cycle WAIT_CYCLES+1 edges after the accepting edge; ready is low over that span; throughput one transaction per WAIT_CYCLES+2 cycles.
REQ-020 Request fields SHALL be captured at accept; later changes to inputs have no effect.
REQ-021 Word index = addr[ADDR_W-1:2]; addr[1:0] selects lanes.
REQ-022 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 SHALL set err with done and perform no array write; rdata unchanged.
REQ-023 Store: byte writes lane addr[1:0], half writes lanes addr[1]*2..+1, word all four; other bytes of the word unchanged.
REQ-024 Store commit SHALL occur on the edge entering DONE; a load accepted afterwards returns the new data.
REQ-025 Load: selected byte/half extracted and sign- or zero-extended per uns; word returned unchanged; rdata updated on the edge entering DONE.
REQ-026 err SHALL be 0 whenever done is 0.
REQ-027 Memory contents SHALL be undefined at power-up and never cleared by reset.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, ready 0, done 0, err 0, rdata 0.
REQ-029 ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-030 Reset mid-transaction SHALL abort it: no done pulse; a store not yet committed is discarded.

Structure
REQ-031 Shared package dmem_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-032 Storage SHALL be sub-module dmem_array: 32-bit words, 4-bit byte write enable, synchronous write, combinational read.

Verification
REQ-033 WAIT_CYCLES=0: sw 0x12345678 @0x0 then lw @0x0 -> done one cycle after each accept, rdata 0x12345678, err 0.
REQ-034 After that word: lb @0x3 -> 0x00000012; lb @0x0 after sb 0x80 @0x0 -> 0xFFFFFF80, lbu -> 0x00000080; lh @0x2 -> 0x00001234.
REQ-035 sh 0xBEEF @0x6 on word 0x00000000 @0x4 -> lw @0x4 returns 0xBEEF0000.
REQ-036 lw @0x2, sh @0x1, size=11 @0x0 -> err=1 with done, memory and rdata unchanged.
REQ-037 WAIT_CYCLES=3: accept at edge k -> done in cycle after edge k+4, ready low edges k+1..k+4; req held high gets second accept at edge k+5.
REQ-038 rst_n pulsed low two cycles after accepting sw 0xAAAAAAAA @0x8 (WAIT_CYCLES=3) -> no done, lw @0x8 returns prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory bus: size encodings, FSM state type
// and the lane helpers used by both the controller and its checks.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic bad_access(input logic [1:0] sz, input logic [1:0] lane);
    logic r_bad;
    r_bad = 1'b0;
    case (sz)
      SZ_BYTE: r_bad = 1'b0;
      SZ_HALF: r_bad = lane[0];
      SZ_WORD: r_bad = (lane != 2'b00);
      default: r_bad = 1'b1;
    endcase
    return r_bad;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] r_be;
    r_be = 4'b0000;
    case (sz)
      SZ_BYTE: r_be = 4'b0001 << lane;
      SZ_HALF: r_be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: r_be = 4'b1111;
      default: r_be = 4'b0000;
    endcase
    return r_be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r_lanes;
    r_lanes = d;
    case (sz)
      SZ_BYTE: r_lanes = {4{d[7:0]}};
      SZ_HALF: r_lanes = {2{d[15:0]}};
      default: r_lanes = d;
    endcase
    return r_lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  r_b;
    logic [15:0] r_h;
    logic [31:0] r_out;
    case (lane)
      2'd0:    r_b = word[7:0];
      2'd1:    r_b = word[15:8];
      2'd2:    r_b = word[23:16];
      default: r_b = word[31:24];
    endcase
    r_h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r_out = {{24{~uns & r_b[7]}}, r_b};
      SZ_HALF: r_out = {{16{~uns & r_h[15]}}, r_h};
      default: r_out = word;
    endcase
    return r_out;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables; synchronous write,
// combinational read, no reset so contents survive rst_n.
module dmem_array #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_memory_bus.sv
// Request/ready data memory front end with byte/half/word access, configurable
// wait states and misalignment reporting.
//
//   state   | meaning
//   IDLE    | ready high, waiting for req
//   WAIT    | extra wait cycles counting down to 0
//   DONE    | done pulse; store committed / load result valid
module data_memory_bus #(
  parameter int ADDR_W      = 15,
  parameter int WAIT_CYCLES = 0,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);
  import dmem_pkg::*;

  localparam logic [3:0] WC_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_ready;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_we;
  logic                r_uns;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_accept;
  logic                w_live;
  logic                w_we;
  logic                w_uns;
  logic [1:0]          w_size;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_enter_done;
  logic                w_bad;
  logic [3:0]          w_be;
  logic [31:0]         w_word;
  logic [31:0]         w_load;

  assign w_accept = req && r_ready;

  // With no wait states the access completes on the accepting edge, so the
  // datapath must see the live request instead of the not-yet-captured copy.
  assign w_live  = (r_state == ST_IDLE);
  assign w_we    = w_live ? we    : r_we;
  assign w_uns   = w_live ? uns   : r_uns;
  assign w_size  = w_live ? size  : r_size;
  assign w_addr  = w_live ? addr  : r_addr;
  assign w_wdata = w_live ? wdata : r_wdata;

  assign w_enter_done = ((r_state == ST_IDLE) && w_accept && NO_WAIT) ||
                        ((r_state == ST_WAIT) && (r_cnt == 4'd0));

  assign w_bad  = bad_access(w_size, w_addr[1:0]);
  assign w_be   = (w_enter_done && w_we && !w_bad) ? byte_enable(w_size, w_addr[1:0]) : 4'b0000;
  assign w_load = load_extend(w_word, w_size, w_addr[1:0], w_uns);

  dmem_array #(.AW(ADDR_W-2)) u_array (
    .clk     (clk),
    .i_be    (w_be),
    .i_addr  (w_addr[ADDR_W-1:2]),
    .i_wdata (store_lanes(w_size, w_wdata)),
    .o_rdata (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_enter_done) begin
        r_done <= 1'b1;
        r_err  <= w_bad;
        if (!w_we && !w_bad) r_rdata <= w_load;
      end
      case (r_state)
        ST_IDLE: begin
          r_ready <= !w_accept;
          if (w_accept) begin
            r_we    <= we;
            r_uns   <= uns;
            r_size  <= size;
            r_addr  <= addr;
            r_wdata <= wdata;
            if (NO_WAIT) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WC_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_data_memory_bus.sv
// Directed checks of data_memory_bus with zero and three wait states.
module tb_data_memory_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [14:0] addr = '0;
  logic [31:0] wdata = '0;
  int          sel = 0;

  logic        req0, req1;
  logic        ready0, done0, err0, ready1, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic        ready_s, done_s, err_s;
  logic [31:0] rdata_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign req0    = req & (sel == 0);
  assign req1    = req & (sel == 1);
  assign ready_s = (sel == 1) ? ready1 : ready0;
  assign done_s  = (sel == 1) ? done1  : done0;
  assign err_s   = (sel == 1) ? err1   : err0;
  assign rdata_s = (sel == 1) ? rdata1 : rdata0;

  data_memory_bus #(.ADDR_W(15), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready0), .done(done0), .err(err0), .rdata(rdata0)
  );

  data_memory_bus #(.ADDR_W(15), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready1), .done(done1), .err(err1), .rdata(rdata1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction; inputs are scrambled after acceptance to show
  // that the captured copy is what completes.
  task automatic txn(input int s, input logic w, input logic [1:0] sz, input logic u,
                     input logic [14:0] a, input logic [31:0] d,
                     output logic e, output logic [31:0] rd, output int lat);
    int n;
    sel = s;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
    n = 0;
    while (!ready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(ready_s), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; size = ~sz; uns = ~u; addr = ~a; wdata = ~d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done_s && lat < 30);
    if (lat >= 30) chk("done_timeout", 32'(done_s), 32'd1);
    e  = err_s;
    rd = rdata_s;
    @(negedge clk);
    chk("done_one_cycle", 32'(done_s), 32'd0);
    chk("err_without_done", 32'(err_s), 32'd0);
  endtask

  logic        e;
  logic [31:0] rd;
  int          lat;
  logic [4:0]  rdy_vec, done_vec;
  logic        saw_done;
  int          n;

  initial begin
    #2;
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_rdata", rdata0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(ready0), 32'd1);

    // WAIT_CYCLES = 0
    txn(0, 1'b1, 2'b10, 1'b0, 15'h0, 32'h12345678, e, rd, lat);
    chk("sw_lat", 32'(lat), 32'd1);
    chk("sw_err", 32'(e), 32'd0);
    txn(0, 1'b0, 2'b10, 1'b0, 15'h0, 32'h0, e, rd, lat);
    chk("lw_lat", 32'(lat), 32'd1);
    chk("lw_err", 32'(e), 32'd0);
    chk("lw0", rd, 32'h12345678);
    txn(0, 1'b0, 2'b00, 1'b0, 15'h3, 32'h0, e, rd, lat);
    chk("lb3", rd, 32'h00000012);
    txn(0, 1'b0, 2'b01, 1'b0, 15'h2, 32'h0, e, rd, lat);
    chk("lh2", rd, 32'h00001234);
    txn(0, 1'b1, 2'b00, 1'b0, 15'h0, 32'hFFFFFF80, e, rd, lat);
    txn(0, 1'b0, 2'b00, 1'b0, 15'h0, 32'h0, e, rd, lat);
    chk("lb0_signed", rd, 32'hFFFFFF80);
    txn(0, 1'b0, 2'b00, 1'b1, 15'h0, 32'h0, e, rd, lat);
    chk("lbu0", rd, 32'h00000080);
    txn(0, 1'b0, 2'b10, 1'b0, 15'h0, 32'h0, e, rd, lat);
    chk("lw0_after_sb", rd, 32'h12345680);

    txn(0, 1'b1, 2'b10, 1'b0, 15'h4, 32'h00000000, e, rd, lat);
    txn(0, 1'b1, 2'b01, 1'b0, 15'h6, 32'h0000BEEF, e, rd, lat);
    txn(0, 1'b0, 2'b10, 1'b0, 15'h4, 32'h0, e, rd, lat);
    chk("lw4_after_sh", rd, 32'hBEEF0000);
    txn(0, 1'b0, 2'b01, 1'b0, 15'h6, 32'h0, e, rd, lat);
    chk("lh6_signed", rd, 32'hFFFFBEEF);
    txn(0, 1'b0, 2'b01, 1'b1, 15'h6, 32'h0, e, rd, lat);
    chk("lhu6", rd, 32'h0000BEEF);

    txn(0, 1'b0, 2'b10, 1'b0, 15'h2, 32'h0, e, rd, lat);
    chk("lw2_err", 32'(e), 32'd1);
    chk("lw2_rdata_held", rd, 32'h0000BEEF);
    txn(0, 1'b1, 2'b01, 1'b0, 15'h1, 32'h0000DEAD, e, rd, lat);
    chk("sh1_err", 32'(e), 32'd1);
    txn(0, 1'b1, 2'b11, 1'b0, 15'h0, 32'hCAFEF00D, e, rd, lat);
    chk("rsvd_err", 32'(e), 32'd1);
    chk("rsvd_lat", 32'(lat), 32'd1);
    txn(0, 1'b0, 2'b11, 1'b0, 15'h4, 32'h0, e, rd, lat);
    chk("rsvd_load_err", 32'(e), 32'd1);
    chk("rsvd_load_rdata_held", rd, 32'h0000BEEF);
    txn(0, 1'b0, 2'b10, 1'b0, 15'h0, 32'h0, e, rd, lat);
    chk("lw0_untouched", rd, 32'h12345680);
    txn(0, 1'b0, 2'b10, 1'b0, 15'h4, 32'h0, e, rd, lat);
    chk("lw4_untouched", rd, 32'hBEEF0000);

    // WAIT_CYCLES = 3
    txn(1, 1'b1, 2'b10, 1'b0, 15'h8, 32'h11223344, e, rd, lat);
    chk("w3_sw_lat", 32'(lat), 32'd4);

    sel = 1;
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 15'h8; req = 1'b1;
    n = 0;
    while (!ready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w3_ready_timeout", 32'(ready_s), 32'd1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rdy_vec[i]  = ready_s;
      done_vec[i] = done_s;
      if (i == 3) chk("w3_lw8", rdata_s, 32'h11223344);
    end
    chk("w3_ready_pattern", 32'(rdy_vec), 32'h10);
    chk("w3_done_pattern", 32'(done_vec), 32'h08);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("w3_second_accept", 32'(ready_s), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_s && n < 20);
    chk("w3_second_lat", 32'(n), 32'd4);

    // Reset mid-store: accept, two edges later pull rst_n low.
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 15'h8; wdata = 32'hAAAAAAAA; req = 1'b1;
    n = 0;
    while (!ready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rst_ready_timeout", 32'(ready_s), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_done", 32'(done1), 32'd0);
    chk("midrst_ready", 32'(ready1), 32'd0);
    chk("midrst_rdata", rdata1, 32'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= done1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_rise", 32'(ready1), 32'd1);
    repeat (5) begin
      @(negedge clk);
      saw_done |= done1;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    txn(1, 1'b0, 2'b10, 1'b0, 15'h8, 32'h0, e, rd, lat);
    chk("midrst_lw8", rd, 32'h11223344);
    txn(0, 1'b0, 2'b10, 1'b0, 15'h0, 32'h0, e, rd, lat);
    chk("mem_survives_rst", rd, 32'h12345680);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
